// File: rtl/rr_mux_pkg.sv
// Shared encodings for the round-robin N:1 mux.
// Mode select values and output-register state.
package rr_mux_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_MAN = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request
// at or after ptr+1, wrapping, wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [SW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  int c;

  // Scan from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    c         = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(ptr_i) + k) % N;
      if (req_i[c]) begin
        gnt_oh_o    = '0;
        gnt_oh_o[c] = 1'b1;
        gnt_idx_o   = SW'(c);
        gnt_vld_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// N:1 valid/ready mux with round-robin or manual select
// feeding a single registered output beat.
module rr_mux_nx1
  import rr_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  y_ch,
  output logic           y_valid,
  input  logic           y_ready
);

  localparam int NP = 2 ** SW;

  ostate_e       state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  rr_oh;
  logic [SW-1:0] rr_idx;
  logic          rr_vld;

  logic [NP-1:0] vld_pad;
  logic [NP-1:0] man_pad;

  logic [N-1:0]  gnt_oh;
  logic [SW-1:0] gnt_idx;
  logic          gnt_vld;
  logic [W-1:0]  gnt_data;
  logic          load;
  logic          xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req_i    (in_valid),
    .ptr_i    (ptr_q),
    .gnt_oh_o (rr_oh),
    .gnt_idx_o(rr_idx),
    .gnt_vld_o(rr_vld)
  );

  // Padding lets an out-of-range s fall on a zero request bit.
  always_comb begin
    vld_pad           = '0;
    vld_pad[N-1:0]    = in_valid;
    man_pad           = '0;
    man_pad[s]        = vld_pad[s];
  end

  always_comb begin
    gnt_oh  = rr_oh;
    gnt_idx = rr_idx;
    gnt_vld = rr_vld;
    if (mode == MODE_MAN) begin
      gnt_oh  = man_pad[N-1:0];
      gnt_idx = s;
      gnt_vld = vld_pad[s];
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) gnt_data = in_data[i*W +: W];
    end
  end

  assign load     = (state_q == EMPTY) || y_ready;
  assign xfer     = load && gnt_vld && !rst;
  assign in_ready = xfer ? gnt_oh : '0;

  assign y       = y_q;
  assign y_ch    = ch_q;
  assign y_valid = (state_q == FULL);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = FULL;
      y_d     = gnt_data;
      ch_d    = gnt_idx;
      ptr_d   = gnt_idx;
    end else if (load) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      y_q     <= '0;
      ch_q    <= '0;
      ptr_q   <= SW'(N - 1);
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Bench for rr_mux_nx1: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_rr_mux_nx1;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [SW-1:0]  s;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   y;
  logic [SW-1:0]  y_ch;
  logic           y_valid;
  logic           y_ready;

  always #5 clk = ~clk;

  rr_mux_nx1 #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .s       (s),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .y       (y),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  int checks = 0;
  int errors = 0;

  bit m_vld = 0;
  int m_y   = 0;
  int m_ch  = 0;
  int m_ptr = N - 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_grant();
    if (mode) return (int'(s) < N && in_valid[s]) ? int'(s) : -1;
    for (int k = 1; k <= N; k++) begin
      int c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic cyc();
    int g;
    bit ld;
    logic [N-1:0] exp_rdy;
    #1;
    ld = !m_vld || y_ready;
    g  = ref_grant();
    exp_rdy = (!rst && ld && g >= 0) ? N'(1 << g) : '0;
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_y = 0; m_ch = 0; m_ptr = N - 1;
    end else if (ld) begin
      if (g >= 0) begin
        m_vld = 1; m_y = in_data[g*W +: W]; m_ch = g; m_ptr = g;
      end else begin
        m_vld = 0;
      end
    end
    #1;
    chk("y_valid", y_valid, m_vld);
    chk("y", y, m_y);
    chk("y_ch", y_ch, m_ch);
  endtask

  initial begin
    rst = 1; mode = 0; s = 0; in_valid = '0;
    in_data = '0; y_ready = 1;
    cyc();
    chk("rst_yv", y_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_ch", y_ch, 0);

    // round-robin walk from channel 0
    rst = 0; in_valid = 4'b1111;
    in_data = 32'h44_33_22_11;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_seq", y_ch, i % N);
    end

    // manual select of channel 2
    mode = 1; s = 2; in_valid = 4'b0100;
    in_data = 32'h00_A5_00_00;
    #1;
    chk("man_rdy", in_ready, 4'b0100);
    cyc();
    chk("man_y", y, 8'hA5);
    chk("man_ch", y_ch, 2);
    chk("man_yv", y_valid, 1);

    // hold under backpressure
    s = 0; in_valid = 4'b1111; in_data = 32'h01_02_03_3C;
    cyc();
    mode = 0; y_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      cyc();
      chk("hold_y", y, 8'h3C);
      chk("hold_v", y_valid, 1);
      chk("hold_rdy", in_ready, 0);
    end

    // ptr=0, then 1001 alternates 3,0,3
    y_ready = 1; rst = 1; cyc();
    rst = 0; in_valid = 4'b0001; cyc();
    in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("alt_ch", y_ch, (i % 2 == 0) ? 3 : 0);
    end
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lone_ch", y_ch, 1);
      chk("lone_v", y_valid, 1);
    end

    // manual select of an idle channel drains to empty
    mode = 1; s = 1; in_valid = 4'b1101;
    cyc();
    chk("nogr_v", y_valid, 0);

    // reset mid-stream
    mode = 0; in_valid = 4'b1111; in_data = 32'hDE_AD_BE_EF;
    cyc(); cyc();
    rst = 1; cyc();
    chk("mrst_v", y_valid, 0);
    chk("mrst_y", y, 0);
    chk("mrst_ch", y_ch, 0);
    rst = 0; cyc();
    chk("mrst_first", y_ch, 0);

    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      mode     = $urandom_range(0, 3) == 0;
      s        = SW'($urandom);
      in_valid = N'($urandom);
      in_data  = $urandom;
      y_ready  = $urandom_range(0, 9) < 7;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
